// File: rtl/spi_reg_bank_pkg.sv
// rtl/spi_reg_bank_pkg.sv - shared address map and field indices for spi_reg_bank
package spi_reg_bank_pkg;
   localparam int ADDR_CTRL     = 0;
   localparam int ADDR_STATUS   = 1;
   localparam int ADDR_IRQ_MASK = 2;
   localparam int ADDR_EVT_CNT  = 3;
   localparam int ADDR_SHADOW0  = 4;

   localparam int CTRL_COMMIT   = 0;
   localparam int CTRL_IRQ_EN   = 1;

   localparam int NUM_SLOTS     = 4;
endpackage

// File: rtl/spi_reg_bank_if.sv
// rtl/spi_reg_bank_if.sv - register access bus between SPI front end and register bank
interface spi_reg_bank_if #(
   parameter int ADDR_W = 3,
   parameter int REG_W  = 8
) ();
   logic [ADDR_W-1:0] reg_addr;
   logic [REG_W-1:0]  wr_data;
   logic              wr_dv;
   logic [REG_W-1:0]  rd_data;

   modport master (output reg_addr, output wr_data, output wr_dv, input rd_data);
   modport slave  (input reg_addr, input wr_data, input wr_dv, output rd_data);
endinterface

// File: rtl/spi_reg_bank_evt.sv
// rtl/spi_reg_bank_evt.sv - sticky W1C status and saturating event counter
module spi_reg_bank_evt #(
   parameter int REG_W = 8
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             ena,
   input  logic [REG_W-1:0] evt_i,
   input  logic [REG_W-1:0] sts_w1c,
   input  logic             cnt_clr,
   output logic [REG_W-1:0] status,
   output logic [REG_W-1:0] status_next,
   output logic [REG_W-1:0] evt_cnt
);
   logic [REG_W-1:0] cnt_next;

   // Clear first, then OR in new events so a simultaneous set wins
   always_comb begin
      status_next = (status & ~sts_w1c) | evt_i;
   end

   // Counter clear beats increment; increment stops at all-ones
   always_comb begin
      cnt_next = evt_cnt;
      if (cnt_clr) begin
         cnt_next = '0;
      end else if ((|evt_i) && (evt_cnt != '1)) begin
         cnt_next = evt_cnt + REG_W'(1);
      end
   end

   // State registers, frozen while ena is low
   always_ff @(posedge clk) begin
      if (!rstb) begin
         status  <= '0;
         evt_cnt <= '0;
      end else if (ena) begin
         status  <= status_next;
         evt_cnt <= cnt_next;
      end
   end
endmodule

// File: rtl/spi_reg_bank.sv
// rtl/spi_reg_bank.sv - register bank with double-buffered outputs behind SPI front end
module spi_reg_bank
   import spi_reg_bank_pkg::*;
#(
   parameter int ADDR_W = 3,
   parameter int REG_W  = 8
) (
   input  logic               clk,
   input  logic               rstb,
   input  logic               ena,
   spi_reg_bank_if.slave      bus,
   input  logic [REG_W-1:0]   evt_i,
   output logic [REG_W-3:0]   ctrl_o,
   output logic [4*REG_W-1:0] out_o,
   output logic               irq_o
);
   logic [2:0]       idx;
   logic             in_range;
   logic             wr_en;
   logic             wr_ctrl;
   logic             wr_status;
   logic             wr_mask;
   logic             wr_cnt;
   logic             wr_shadow;
   logic [1:0]       slot;
   logic             commit;

   logic [REG_W-1:1] ctrl_q;
   logic [REG_W-1:1] ctrl_next;
   logic [REG_W-1:0] mask_q;
   logic [REG_W-1:0] mask_next;
   logic [REG_W-1:0] shadow [NUM_SLOTS];
   logic [REG_W-1:0] status;
   logic [REG_W-1:0] status_next;
   logic [REG_W-1:0] evt_cnt;
   logic [REG_W-1:0] sts_w1c;
   logic [REG_W-1:0] rd_next;
   logic             irq_next;

   assign idx      = bus.reg_addr[2:0];
   assign in_range = ((bus.reg_addr >> 3) == '0);
   assign slot     = 2'(idx - 3'(ADDR_SHADOW0));
   assign ctrl_o   = ctrl_q[REG_W-1:2];

   // Address decode; anything at or above 8 is silently dropped
   always_comb begin
      wr_en     = bus.wr_dv & in_range;
      wr_ctrl   = wr_en && (idx == 3'(ADDR_CTRL));
      wr_status = wr_en && (idx == 3'(ADDR_STATUS));
      wr_mask   = wr_en && (idx == 3'(ADDR_IRQ_MASK));
      wr_cnt    = wr_en && (idx == 3'(ADDR_EVT_CNT));
      wr_shadow = wr_en && (idx >= 3'(ADDR_SHADOW0));
      commit    = wr_ctrl && bus.wr_data[CTRL_COMMIT];
      sts_w1c   = wr_status ? bus.wr_data : '0;
   end

   // Post-write values feed the interrupt so irq_o tracks the same edge
   always_comb begin
      ctrl_next = wr_ctrl ? bus.wr_data[REG_W-1:1] : ctrl_q;
      mask_next = wr_mask ? bus.wr_data : mask_q;
      irq_next  = ctrl_next[CTRL_IRQ_EN] & (|(status_next & mask_next));
   end

   // Read mux over current (pre-write) register values; COMMIT reads as 0
   always_comb begin
      rd_next = '0;
      if (in_range) begin
         case (idx)
            3'(ADDR_CTRL):     rd_next = {ctrl_q, 1'b0};
            3'(ADDR_STATUS):   rd_next = status;
            3'(ADDR_IRQ_MASK): rd_next = mask_q;
            3'(ADDR_EVT_CNT):  rd_next = evt_cnt;
            default:           rd_next = shadow[slot];
         endcase
      end
   end

   spi_reg_bank_evt #(.REG_W(REG_W)) u_evt (
      .clk         (clk),
      .rstb        (rstb),
      .ena         (ena),
      .evt_i       (evt_i),
      .sts_w1c     (sts_w1c),
      .cnt_clr     (wr_cnt),
      .status      (status),
      .status_next (status_next),
      .evt_cnt     (evt_cnt)
   );

   // Control, mask, shadows and the atomic four-slot commit
   always_ff @(posedge clk) begin
      if (!rstb) begin
         ctrl_q      <= '0;
         mask_q      <= '0;
         irq_o       <= 1'b0;
         bus.rd_data <= '0;
         out_o       <= '0;
         for (int k = 0; k < NUM_SLOTS; k++) begin
            shadow[k] <= '0;
         end
      end else if (ena) begin
         ctrl_q      <= ctrl_next;
         mask_q      <= mask_next;
         irq_o       <= irq_next;
         bus.rd_data <= rd_next;
         if (wr_shadow) begin
            shadow[slot] <= bus.wr_data;
         end
         if (commit) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
               out_o[k*REG_W +: REG_W] <= shadow[k];
            end
         end
      end
   end
endmodule

// File: tb/tb_spi_reg_bank.sv
// tb/tb_spi_reg_bank.sv - randomized self-checking bench for spi_reg_bank
module tb_spi_reg_bank;
   localparam int ADDR_W = 4;
   localparam int REG_W  = 8;

   logic               clk = 1'b0;
   logic               rstb;
   logic               ena;
   logic [REG_W-1:0]   evt_i;
   logic [REG_W-3:0]   ctrl_o;
   logic [4*REG_W-1:0] out_o;
   logic               irq_o;

   int n_checks = 0;
   int n_pass   = 0;

   int m_ctrl, m_status, m_mask, m_cnt, m_irq, m_rd;
   int m_shadow [4];
   int m_out    [4];

   spi_reg_bank_if #(.ADDR_W(ADDR_W), .REG_W(REG_W)) bus ();

   spi_reg_bank #(.ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
      .clk    (clk),
      .rstb   (rstb),
      .ena    (ena),
      .bus    (bus.slave),
      .evt_i  (evt_i),
      .ctrl_o (ctrl_o),
      .out_o  (out_o),
      .irq_o  (irq_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   // Reference model: one clock edge worth of register-bank behaviour
   task automatic model_edge(input bit r, input bit e, input int a, input int wd,
                             input bit wv, input int ev);
      int clr;
      int cclr;
      int rd;
      if (!r) begin
         m_ctrl = 0; m_status = 0; m_mask = 0; m_cnt = 0; m_irq = 0; m_rd = 0;
         for (int k = 0; k < 4; k++) begin m_shadow[k] = 0; m_out[k] = 0; end
      end else if (e) begin
         clr = 0; cclr = 0;
         case (a)
            0: rd = m_ctrl;
            1: rd = m_status;
            2: rd = m_mask;
            3: rd = m_cnt;
            4, 5, 6, 7: rd = m_shadow[a-4];
            default: rd = 0;
         endcase
         if (wv && a < 8) begin
            case (a)
               0: begin
                  m_ctrl = wd & 'hFE;
                  if (wd % 2 == 1) for (int k = 0; k < 4; k++) m_out[k] = m_shadow[k];
               end
               1: clr = wd;
               2: m_mask = wd;
               3: cclr = 1;
               default: m_shadow[a-4] = wd;
            endcase
         end
         m_status = (m_status & ~clr & 'hFF) | ev;
         if (cclr) m_cnt = 0;
         else if (ev != 0) m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
         m_irq = (((m_ctrl >> 1) & 1) == 1 && (m_status & m_mask) != 0) ? 1 : 0;
         m_rd = rd;
      end
   endtask

   // One clock: model follows the edge, then every visible output is compared
   task automatic step();
      bit r, e, wv;
      int a, wd, ev;
      logic [31:0] exp_out;
      r = rstb; e = ena; a = int'(bus.reg_addr); wd = int'(bus.wr_data);
      wv = bus.wr_dv; ev = int'(evt_i);
      @(posedge clk);
      model_edge(r, e, a, wd, wv, ev);
      #1;
      exp_out = {m_out[3][7:0], m_out[2][7:0], m_out[1][7:0], m_out[0][7:0]};
      check("rd_data", 64'(bus.rd_data), 64'(m_rd));
      check("out_o",   64'(out_o),       64'(exp_out));
      check("ctrl_o",  64'(ctrl_o),      64'((m_ctrl >> 2) & 'h3F));
      check("irq_o",   64'(irq_o),       64'(m_irq));
   endtask

   task automatic wr(input int a, input int d);
      bus.reg_addr = ADDR_W'(a); bus.wr_data = REG_W'(d); bus.wr_dv = 1'b1;
      step();
      bus.wr_dv = 1'b0;
   endtask

   task automatic rd(input int a, input string tag, input int exp);
      bus.reg_addr = ADDR_W'(a); bus.wr_dv = 1'b0;
      step();
      check(tag, 64'(bus.rd_data), 64'(exp));
   endtask

   initial begin
      rstb = 1'b0; ena = 1'b1; evt_i = '0;
      bus.reg_addr = '0; bus.wr_data = '0; bus.wr_dv = 1'b0;
      step(); step();
      rstb = 1'b1;

      for (int a = 0; a < 8; a++) rd(a, "reset_read", 0);
      check("reset_out", 64'(out_o), 64'h0);
      check("reset_irq", 64'(irq_o), 64'h0);

      wr(4, 'h11); wr(5, 'h22); wr(6, 'h33); wr(7, 'h44);
      check("shadow_no_out", 64'(out_o), 64'h0);
      wr(0, 'h01);
      check("commit_out", 64'(out_o), 64'h44332211);
      rd(0, "ctrl_commit_reads0", 0);
      rd(5, "shadow1_read", 'h22);

      wr(2, 'h04); wr(0, 'h02);
      evt_i = 8'h05; step(); evt_i = 8'h00;
      check("evt_irq", 64'(irq_o), 64'h1);
      rd(1, "status_set", 'h05);
      wr(1, 'h04);
      check("w1c_irq", 64'(irq_o), 64'h0);
      rd(1, "status_w1c", 'h01);

      evt_i = 8'h01; wr(1, 'h01); evt_i = 8'h00;
      rd(1, "set_wins", 'h01);

      bus.reg_addr = ADDR_W'(3); evt_i = 8'h01;
      for (int i = 0; i < 300; i++) step();
      evt_i = 8'h00;
      rd(3, "cnt_sat", 'hFF);
      evt_i = 8'h01; wr(3, 'h5A); evt_i = 8'h00;
      rd(3, "cnt_clr_wins", 0);

      wr(12, 'hAB);
      rd(12, "oor_read", 0);

      ena = 1'b0;
      for (int i = 0; i < 10; i++) begin
         evt_i = REG_W'($urandom); bus.reg_addr = ADDR_W'($urandom_range(0, 7));
         bus.wr_data = REG_W'($urandom); bus.wr_dv = 1'b1;
         step();
      end
      bus.wr_dv = 1'b0; evt_i = '0;
      rstb = 1'b0; step(); rstb = 1'b1;
      check("rst_ena0_out", 64'(out_o), 64'h0);
      check("rst_ena0_irq", 64'(irq_o), 64'h0);
      check("rst_ena0_ctrl", 64'(ctrl_o), 64'h0);
      ena = 1'b1;

      for (int i = 0; i < 3000; i++) begin
         rstb = ($urandom_range(0, 199) != 0);
         ena  = ($urandom_range(0, 9) != 0);
         bus.reg_addr = ADDR_W'($urandom_range(0, 15));
         bus.wr_data  = REG_W'($urandom);
         bus.wr_dv    = ($urandom_range(0, 2) == 0);
         evt_i = ($urandom_range(0, 3) == 0) ? REG_W'($urandom) : '0;
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
